udp_depacketizer: RTL



---
 rtl/udp_pkt_pkg.sv | 38 +++
 rtl/sat_counter16.sv | 21 ++
 rtl/udp_depacketizer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/udp_pkt_pkg.sv
// Shared constants and types for the UDP packetizer/depacketizer pair:
// protocol field values, header word indices and the receive FSM state type.
package udp_pkt_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] UDP_HDR_BYTES  = 16'd8;
    localparam logic [15:0] UDP_MIN_LEN    = 16'd12;

    // Word positions in the 32-bit stream (RX_SHIFT16 pad in word 0)
    localparam logic [3:0] HW_DST_HI      = 4'd0;
    localparam logic [3:0] HW_DST_LO      = 4'd1;
    localparam logic [3:0] HW_SRC_HI      = 4'd2;
    localparam logic [3:0] HW_SRC_LO_TYPE = 4'd3;
    localparam logic [3:0] HW_VER_LEN     = 4'd4;
    localparam logic [3:0] HW_ID_FRAG     = 4'd5;
    localparam logic [3:0] HW_TTL_PROTO   = 4'd6;
    localparam logic [3:0] HW_SRC_IP      = 4'd7;
    localparam logic [3:0] HW_DST_IP      = 4'd8;
    localparam logic [3:0] HW_PORTS       = 4'd9;
    localparam logic [3:0] HW_UDP_LEN     = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_DROP
    } depkt_state_t;

    // Whole 32-bit payload words carried by a datagram; trailing bytes are dropped.
    function automatic logic [13:0] payload_words(input logic [15:0] udp_len);
        logic [15:0] bytes;
        bytes = udp_len - UDP_HDR_BYTES;
        return bytes[15:2];
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up/down event counter that sticks at 0 and 16'hFFFF instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        dec,
    output logic [15:0] count
);

    // NOTE: synchronous reset inside the clocked block; nothing outside this edge sees rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 16'd0;
        end else if (inc && !dec && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end else if (dec && !inc && count != 16'd0) begin
            count <= count - 16'd1;
        end
    end

endmodule

// File: rtl/udp_depacketizer.sv
// Ethernet/IPv4/UDP receive parser: filters frames for this node and forwards payload words.
// Optional source filtering is enabled by defining UDP_DEPKT_SRC_FILTER_EN.
module udp_depacketizer
    import udp_pkt_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h021234566790,
    parameter logic [31:0] LOCAL_IP   = {8'd10, 8'd0, 8'd0, 8'd2},
    parameter logic [15:0] LOCAL_PORT = 16'd32179,
    parameter logic [31:0] PEER_IP    = {8'd10, 8'd0, 8'd0, 8'd1},
    parameter logic [15:0] PEER_PORT  = 16'd32179
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ff_rx_clk,
    input  logic [31:0] ff_rx_data,
    input  logic        ff_rx_sop,
    input  logic        ff_rx_eop,
    input  logic        ff_rx_dval,
    input  logic [1:0]  ff_rx_mod,
    input  logic [5:0]  rx_err,
    output logic        ff_rx_rdy,
    output logic [31:0] out_data,
    output logic        out_wren,
    output logic        out_last,
    output logic        out_abort,
    input  logic        out_afull,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_drop
);

`ifdef UDP_DEPKT_SRC_FILTER_EN
    localparam logic SRC_FILTER = 1'b1;
`else
    localparam logic SRC_FILTER = 1'b0;
`endif

    depkt_state_t state, state_next;
    logic [3:0]   hw, hw_next;
    logic [13:0]  pay_cnt, pay_cnt_next;
    logic         dst_hi_ok, dst_hi_ok_next;
    logic         done_ok, done_ok_next;
    logic         abort_pend, abort_pend_next;
    logic         hdr_match;
    logic         wr, last, abort, ok_inc, ok_dec, drop_inc;
    logic         mod_unused;

    assign ff_rx_clk  = clk;
    assign mod_unused = ^ff_rx_mod;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        hdr_match = 1'b1;
        case (hw)
            HW_DST_LO:      hdr_match = dst_hi_ok && (ff_rx_data == LOCAL_MAC[31:0]);
            HW_SRC_HI:      hdr_match = 1'b1;
            HW_SRC_LO_TYPE: hdr_match = (ff_rx_data[15:0] == ETHERTYPE_IPV4);
            HW_VER_LEN:     hdr_match = (ff_rx_data[31:24] == IP_VER_IHL);
            HW_ID_FRAG:     hdr_match = (ff_rx_data[13:0] == 14'd0);
            HW_TTL_PROTO:   hdr_match = (ff_rx_data[23:16] == IP_PROTO_UDP);
            HW_SRC_IP:      hdr_match = !SRC_FILTER || (ff_rx_data == PEER_IP);
            HW_DST_IP:      hdr_match = (ff_rx_data == LOCAL_IP);
            HW_PORTS:       hdr_match = (ff_rx_data[15:0] == LOCAL_PORT) &&
                                        (!SRC_FILTER || (ff_rx_data[31:16] == PEER_PORT));
            HW_UDP_LEN:     hdr_match = (ff_rx_data[31:16] >= UDP_MIN_LEN);
            default:        hdr_match = 1'b1;
        endcase
    end

    always_comb begin
        state_next      = state;
        hw_next         = hw;
        pay_cnt_next    = pay_cnt;
        dst_hi_ok_next  = dst_hi_ok;
        done_ok_next    = done_ok;
        abort_pend_next = 1'b0;
        wr              = 1'b0;
        last            = 1'b0;
        abort           = 1'b0;
        ok_inc          = 1'b0;
        ok_dec          = 1'b0;
        drop_inc        = 1'b0;

        if (ff_rx_dval) begin
            if (ff_rx_sop) begin
                // A sop outside IDLE means the previous eop was lost: close that frame first.
                case (state)
                    ST_HDR: drop_inc = 1'b1;
                    ST_PAY: begin
                        abort    = 1'b1;
                        drop_inc = 1'b1;
                    end
                    default: ;
                endcase
                state_next     = ST_HDR;
                hw_next        = HW_DST_LO;
                dst_hi_ok_next = (ff_rx_data[15:0] == LOCAL_MAC[47:32]);
                done_ok_next   = 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_HDR: begin
                        if (ff_rx_eop) begin
                            drop_inc   = 1'b1;
                            state_next = ST_IDLE;
                        end else if (!hdr_match) begin
                            drop_inc   = 1'b1;
                            state_next = ST_DROP;
                        end else if (hw == HW_UDP_LEN) begin
                            pay_cnt_next = payload_words(ff_rx_data[31:16]);
                            state_next   = ST_PAY;
                        end else begin
                            hw_next = hw + 4'd1;
                        end
                    end
                    ST_PAY: begin
                        if (pay_cnt == 14'd1) begin
                            wr   = 1'b1;
                            last = 1'b1;
                            if (ff_rx_eop) begin
                                state_next = ST_IDLE;
                                // Abort cannot share a cycle with this write, so it trails by one.
                                if (|rx_err) begin
                                    drop_inc        = 1'b1;
                                    abort_pend_next = 1'b1;
                                end else begin
                                    ok_inc = 1'b1;
                                end
                            end else begin
                                ok_inc       = 1'b1;
                                done_ok_next = 1'b1;
                                state_next   = ST_DROP;
                            end
                        end else if (ff_rx_eop) begin
                            // Truncated frame: its eop word is not forwarded, only the abort.
                            abort      = 1'b1;
                            drop_inc   = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            wr           = 1'b1;
                            pay_cnt_next = pay_cnt - 14'd1;
                        end
                    end
                    ST_DROP: begin
                        if (ff_rx_eop) begin
                            state_next = ST_IDLE;
                            if (done_ok && |rx_err) begin
                                abort    = 1'b1;
                                ok_dec   = 1'b1;
                                drop_inc = 1'b1;
                            end
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hw         <= HW_DST_HI;
            pay_cnt    <= 14'd0;
            dst_hi_ok  <= 1'b0;
            done_ok    <= 1'b0;
            abort_pend <= 1'b0;
            out_data   <= 32'd0;
            out_wren   <= 1'b0;
            out_last   <= 1'b0;
            out_abort  <= 1'b0;
            ff_rx_rdy  <= 1'b0;
        end else begin
            state      <= state_next;
            hw         <= hw_next;
            pay_cnt    <= pay_cnt_next;
            dst_hi_ok  <= dst_hi_ok_next;
            done_ok    <= done_ok_next;
            abort_pend <= abort_pend_next;
            out_wren   <= wr;
            out_last   <= last;
            out_abort  <= abort | abort_pend;
            ff_rx_rdy  <= ~out_afull;
            if (wr) begin
                out_data <= ff_rx_data;
            end
        end
    end

    sat_counter16 u_frames_ok (
        .clk   (clk),
        .rst   (rst),
        .inc   (ok_inc),
        .dec   (ok_dec),
        .count (frames_ok)
    );

    sat_counter16 u_frames_drop (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .dec   (1'b0),
        .count (frames_drop)
    );

endmodule
